// File: rtl/rgb_led_pwm_ctrl.sv
// rgb_led_pwm_ctrl
//   N-LED RGB PWM controller. Each LED has a mode (OFF/STATIC/BLINK/BREATHE)
//   and three colour duties, loaded one LED at a time through a valid/ready
//   config port. A new config is held in a single shadow register. It is
//   copied into the LED's active registers only at a PWM period boundary, so
//   an output never changes duty in the middle of a period.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low
//   cfg_valid  config request
//   cfg_ready  config accept; a transfer happens on cfg_valid && cfg_ready
//   cfg_idx    target LED index
//   cfg_mode   0=OFF 1=STATIC 2=BLINK 3=BREATHE
//   cfg_r/g/b  colour duties
//   cfg_err    one-cycle pulse after a transfer whose cfg_idx is out of range
//   pwm_sync   one-cycle pulse on the first output cycle of each PWM period
//   led_r/g/b  registered PWM outputs, active high, one bit per LED
module rgb_led_pwm_ctrl #(
  parameter int CLK_FREQ   = 12000000,
  parameter int PWM_FREQ   = 20000,
  parameter int N_LEDS     = 2,
  parameter int DUTY_W     = 8,
  parameter int BLINK_HZ   = 2,
  parameter int BREATHE_HZ = 512,
  localparam int IDX_W     = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [1:0]        cfg_mode,
  input  logic [DUTY_W-1:0] cfg_r,
  input  logic [DUTY_W-1:0] cfg_g,
  input  logic [DUTY_W-1:0] cfg_b,
  output logic              cfg_err,
  output logic              pwm_sync,
  output logic [N_LEDS-1:0] led_r,
  output logic [N_LEDS-1:0] led_g,
  output logic [N_LEDS-1:0] led_b
);

  localparam int MAX         = (1 << DUTY_W) - 1;
  localparam int PRESC_RAW   = CLK_FREQ / (PWM_FREQ * MAX);
  localparam int PRESC       = (PRESC_RAW < 1) ? 1 : PRESC_RAW;
  localparam int BLINK_RAW   = CLK_FREQ / (2 * BLINK_HZ);
  localparam int BLINK_DIV   = (BLINK_RAW < 1) ? 1 : BLINK_RAW;
  localparam int BRTH_RAW    = CLK_FREQ / BREATHE_HZ;
  localparam int BRTH_DIV    = (BRTH_RAW < 1) ? 1 : BRTH_RAW;
  localparam int PRESC_W     = $clog2(PRESC + 1);
  localparam int BLINK_W     = $clog2(BLINK_DIV + 1);
  localparam int BRTH_W      = $clog2(BRTH_DIV + 1);
  localparam int PW          = 2 * DUTY_W + 1;

  localparam logic [DUTY_W-1:0] MAX_V    = DUTY_W'(MAX);
  localparam logic [DUTY_W-1:0] LAST_CNT = DUTY_W'(MAX - 1);
  localparam logic [DUTY_W-1:0] ONE_D    = DUTY_W'(1);
  localparam logic [31:0]       N_LEDS_U = 32'(N_LEDS);

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_STATIC = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;

  // Timebase and shared pattern generators
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [DUTY_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [BRTH_W-1:0]  brth_cnt_q, brth_cnt_d;
  logic [DUTY_W-1:0]  env_q, env_d;
  logic               env_up_q, env_up_d;
  logic               presc_tick;
  logic               at_boundary;
  logic [DUTY_W:0]    env_p1;

  // Config path
  logic                   pending_q, pending_d;
  logic [IDX_W-1:0]       sh_idx_q, sh_idx_d;
  logic [1:0]             sh_mode_q, sh_mode_d;
  logic [2:0][DUTY_W-1:0] sh_duty_q, sh_duty_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   pwm_sync_q, pwm_sync_d;
  logic                   accept;
  logic                   idx_bad;
  logic                   apply;

  // Per-LED state; colour index 0=r, 1=g, 2=b
  logic [N_LEDS-1:0][1:0]             mode_q, mode_d;
  logic [N_LEDS-1:0][2:0][DUTY_W-1:0] duty_q, duty_d;
  logic [N_LEDS-1:0][2:0][DUTY_W-1:0] eff_q, eff_d;
  logic [N_LEDS-1:0][2:0]             led_q, led_d;

  assign presc_tick  = (presc_cnt_q == PRESC_W'(PRESC - 1));
  // The first cycle of a period is the only one with both counters at zero,
  // including the very first cycle after reset.
  assign at_boundary = (presc_cnt_q == '0) && (pwm_cnt_q == '0);
  assign env_p1      = {1'b0, env_q} + (DUTY_W + 1)'(1);

  always_comb begin
    presc_cnt_d   = presc_tick ? '0 : presc_cnt_q + PRESC_W'(1);
    pwm_cnt_d     = pwm_cnt_q;
    if (presc_tick) begin
      pwm_cnt_d = (pwm_cnt_q == LAST_CNT) ? '0 : pwm_cnt_q + ONE_D;
    end

    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end

    // Triangle envelope: direction flips on the endpoint itself, so neither
    // 0 nor MAX is held for two steps.
    brth_cnt_d = brth_cnt_q + BRTH_W'(1);
    env_d      = env_q;
    env_up_d   = env_up_q;
    if (brth_cnt_q == BRTH_W'(BRTH_DIV - 1)) begin
      brth_cnt_d = '0;
      if (env_up_q) begin
        if (env_q == MAX_V) begin
          env_d    = env_q - ONE_D;
          env_up_d = 1'b0;
        end else begin
          env_d = env_q + ONE_D;
        end
      end else begin
        if (env_q == '0) begin
          env_d    = env_q + ONE_D;
          env_up_d = 1'b1;
        end else begin
          env_d = env_q - ONE_D;
        end
      end
    end
  end

  assign cfg_ready = ~pending_q;
  assign accept    = cfg_valid && cfg_ready;
  assign idx_bad   = ({{(32 - IDX_W){1'b0}}, cfg_idx} >= N_LEDS_U);
  assign apply     = at_boundary && pending_q;

  always_comb begin
    pending_d  = pending_q;
    sh_idx_d   = sh_idx_q;
    sh_mode_d  = sh_mode_q;
    sh_duty_d  = sh_duty_q;
    cfg_err_d  = 1'b0;
    pwm_sync_d = at_boundary;
    if (apply) begin
      pending_d = 1'b0;
    end
    // accept and apply are exclusive: accept needs pending_q low.
    if (accept) begin
      if (idx_bad) begin
        cfg_err_d = 1'b1;
      end else begin
        pending_d = 1'b1;
        sh_idx_d  = cfg_idx;
        sh_mode_d = cfg_mode;
        sh_duty_d = {cfg_b, cfg_g, cfg_r};
      end
    end
  end

  // The shadow copy feeds the effective-duty latch in the same cycle, so the
  // period that starts at this boundary already uses the new settings. The
  // LED compare also uses eff_d so the latched duty covers pwm_cnt == 0.
  always_comb begin
    mode_d = mode_q;
    duty_d = duty_q;
    eff_d  = eff_q;
    led_d  = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      if (apply && (sh_idx_q == IDX_W'(i))) begin
        mode_d[i] = sh_mode_q;
        duty_d[i] = sh_duty_q;
      end
      for (int c = 0; c < 3; c++) begin
        if (at_boundary) begin
          case (mode_d[i])
            MODE_OFF:    eff_d[i][c] = '0;
            MODE_STATIC: eff_d[i][c] = duty_d[i][c];
            MODE_BLINK:  eff_d[i][c] = blink_phase_q ? duty_d[i][c] : '0;
            default:     eff_d[i][c] = DUTY_W'((PW'(duty_d[i][c]) * PW'(env_p1)) >> DUTY_W);
          endcase
        end
        led_d[i][c] = (pwm_cnt_q < eff_d[i][c]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_cnt_q   <= '0;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      brth_cnt_q    <= '0;
      env_q         <= '0;
      env_up_q      <= 1'b1;
      pending_q     <= 1'b0;
      sh_idx_q      <= '0;
      sh_mode_q     <= '0;
      sh_duty_q     <= '0;
      cfg_err_q     <= 1'b0;
      pwm_sync_q    <= 1'b0;
      mode_q        <= '0;
      duty_q        <= '0;
      eff_q         <= '0;
      led_q         <= '0;
    end else begin
      presc_cnt_q   <= presc_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      brth_cnt_q    <= brth_cnt_d;
      env_q         <= env_d;
      env_up_q      <= env_up_d;
      pending_q     <= pending_d;
      sh_idx_q      <= sh_idx_d;
      sh_mode_q     <= sh_mode_d;
      sh_duty_q     <= sh_duty_d;
      cfg_err_q     <= cfg_err_d;
      pwm_sync_q    <= pwm_sync_d;
      mode_q        <= mode_d;
      duty_q        <= duty_d;
      eff_q         <= eff_d;
      led_q         <= led_d;
    end
  end

  assign cfg_err  = cfg_err_q;
  assign pwm_sync = pwm_sync_q;

  generate
    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_led_out
      assign led_r[gi] = led_q[gi][0];
      assign led_g[gi] = led_q[gi][1];
      assign led_b[gi] = led_q[gi][2];
    end
  endgenerate

endmodule

// File: tb/tb_rgb_led_pwm_ctrl.sv
// Self-checking bench for rgb_led_pwm_ctrl. A time-based reference model
// derives the counter, blink and envelope values from the cycle number since
// reset. It checks every output on every cycle.
module tb_rgb_led_pwm_ctrl;

  localparam int CLK_FREQ    = 5100000;
  localparam int PWM_FREQ    = 10000;
  localparam int N_LEDS      = 3;
  localparam int DUTY_W      = 8;
  localparam int BLINK_HZ    = 4250;
  localparam int BREATHE_HZ  = 392307;
  // Derived by hand from the parameter set above
  localparam int MAX         = 255;              // 2**8-1
  localparam int PRESC       = 2;                // 5.1e6/(10e3*255)
  localparam int PERIOD      = MAX * PRESC;      // 510 clocks
  localparam int BLINK_DIV   = 600;              // 5.1e6/(2*4250)
  localparam int BREATHE_DIV = 13;               // 5.1e6/392307

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [1:0]        cfg_idx = '0;
  logic [1:0]        cfg_mode = '0;
  logic [DUTY_W-1:0] cfg_r = '0;
  logic [DUTY_W-1:0] cfg_g = '0;
  logic [DUTY_W-1:0] cfg_b = '0;
  logic              cfg_err;
  logic              pwm_sync;
  logic [N_LEDS-1:0] led_r, led_g, led_b;

  always #5 clk = ~clk;

  rgb_led_pwm_ctrl #(
    .CLK_FREQ(CLK_FREQ), .PWM_FREQ(PWM_FREQ), .N_LEDS(N_LEDS),
    .DUTY_W(DUTY_W), .BLINK_HZ(BLINK_HZ), .BREATHE_HZ(BREATHE_HZ)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idx(cfg_idx), .cfg_mode(cfg_mode), .cfg_r(cfg_r), .cfg_g(cfg_g),
    .cfg_b(cfg_b), .cfg_err(cfg_err), .pwm_sync(pwm_sync),
    .led_r(led_r), .led_g(led_g), .led_b(led_b)
  );

  int total = 0;
  int bad   = 0;
  int n     = 0;   // cycles since reset release

  int  m_mode [N_LEDS];
  int  m_duty [N_LEDS][3];
  int  m_eff  [N_LEDS][3];
  bit  m_pend;
  int  sh_idx, sh_mode;
  int  sh_duty [3];
  bit  last_acc;
  logic [N_LEDS-1:0] exp_r, exp_g, exp_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  // Triangle 0..MAX..0 indexed by the number of envelope steps taken.
  function automatic int env_at(input int t);
    int k;
    k = (t / BREATHE_DIV) % (2 * MAX);
    return (k <= MAX) ? k : 2 * MAX - k;
  endfunction

  function automatic int eff_of(input int mode, input int duty, input int t);
    case (mode)
      0:       return 0;
      1:       return duty;
      2:       return (((t / BLINK_DIV) % 2) == 1) ? duty : 0;
      default: return (duty * (env_at(t) + 1)) >> DUTY_W;
    endcase
  endfunction

  task automatic model_reset();
    n = 0;
    m_pend = 1'b0;
    last_acc = 1'b0;
    for (int i = 0; i < N_LEDS; i++) begin
      m_mode[i] = 0;
      for (int c = 0; c < 3; c++) begin
        m_duty[i][c] = 0;
        m_eff[i][c]  = 0;
      end
    end
  endtask

  // One clock: predict the outputs for the next cycle, clock, then compare.
  task automatic tick();
    bit bnd, acc, err;
    int pwm;
    bnd = ((n % PERIOD) == 0);
    acc = cfg_valid && !m_pend;
    if (bnd && m_pend) begin
      m_mode[sh_idx] = sh_mode;
      for (int c = 0; c < 3; c++) m_duty[sh_idx][c] = sh_duty[c];
      m_pend = 1'b0;
    end
    if (bnd) begin
      for (int i = 0; i < N_LEDS; i++)
        for (int c = 0; c < 3; c++)
          m_eff[i][c] = eff_of(m_mode[i], m_duty[i][c], n);
    end
    pwm = (n / PRESC) % MAX;
    for (int i = 0; i < N_LEDS; i++) begin
      exp_r[i] = (pwm < m_eff[i][0]);
      exp_g[i] = (pwm < m_eff[i][1]);
      exp_b[i] = (pwm < m_eff[i][2]);
    end
    err = acc && (int'(cfg_idx) >= N_LEDS);
    if (acc && !err) begin
      m_pend     = 1'b1;
      sh_idx     = int'(cfg_idx);
      sh_mode    = int'(cfg_mode);
      sh_duty[0] = int'(cfg_r);
      sh_duty[1] = int'(cfg_g);
      sh_duty[2] = int'(cfg_b);
    end
    last_acc = acc;
    @(posedge clk);
    n++;
    #1;
    check("led_r", 32'(led_r), 32'(exp_r));
    check("led_g", 32'(led_g), 32'(exp_g));
    check("led_b", 32'(led_b), 32'(exp_b));
    check("pwm_sync", 32'(pwm_sync), 32'(bnd));
    check("cfg_err", 32'(cfg_err), 32'(err));
    check("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
  endtask

  task automatic run(input int k);
    for (int j = 0; j < k; j++) tick();
  endtask

  task automatic wait_at(input int phase);
    for (int j = 0; j < PERIOD && (n % PERIOD) != phase; j++) tick();
  endtask

  task automatic send(input int idx, input int mode, input int r, input int g, input int b);
    cfg_valid = 1'b1;
    cfg_idx   = 2'(idx);
    cfg_mode  = 2'(mode);
    cfg_r     = 8'(r);
    cfg_g     = 8'(g);
    cfg_b     = 8'(b);
    for (int j = 0; j < 2 * PERIOD + 4; j++) begin
      tick();
      if (last_acc) break;
    end
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    cfg_valid = 1'b0;
    rst = 1'b0;
    #1;
    check({tag, "_led_r"}, 32'(led_r), 32'(0));
    check({tag, "_led_g"}, 32'(led_g), 32'(0));
    check({tag, "_led_b"}, 32'(led_b), 32'(0));
    check({tag, "_ready"}, 32'(cfg_ready), 32'(1));
    check({tag, "_err"}, 32'(cfg_err), 32'(0));
    check({tag, "_sync"}, 32'(pwm_sync), 32'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    int hi_a, hi_b;
    #2;
    do_reset("rst0");

    // 1: STATIC r=0x80 on LED0 -> 128 of 255 steps high
    send(0, 1, 'h80, 0, 0);
    wait_at(0);
    hi_a = 0;
    for (int k = 0; k < PERIOD; k++) begin
      tick();
      hi_a += int'(led_r[0]);
    end
    check("t1_high_clocks", 32'(hi_a), 32'(128 * PRESC));

    // 2: duty 0x00 / 0xFF -> constant across 3 periods
    send(1, 1, 'h00, 'hFF, 'hFF);
    wait_at(0);
    hi_a = 0;
    hi_b = 0;
    for (int k = 0; k < 3 * PERIOD; k++) begin
      tick();
      hi_a += int'(led_g[1]);
      hi_b += int'(led_r[1]);
    end
    check("t2_full_on", 32'(hi_a), 32'(3 * PERIOD));
    check("t2_full_off", 32'(hi_b), 32'(0));

    // 3: mid-period write, then a second write blocked while pending
    wait_at(100);
    send(0, 1, 'h40, 'h10, 'h00);
    cfg_valid = 1'b1;
    cfg_r     = 8'hC0;
    run(5);
    check("t3_blocked", 32'(cfg_ready), 32'(0));
    send(0, 1, 'hC0, 'h20, 'h00);
    // accept exactly on a boundary cycle -> applied one period later
    wait_at(0);
    send(0, 2, 'h30, 'h30, 'h30);
    run(PERIOD + 20);

    // 4: out-of-range index -> cfg_err pulse, nothing pending
    send(3, 1, 'hFF, 'hFF, 'hFF);
    check("t4_ready_kept", 32'(cfg_ready), 32'(1));
    run(2 * PERIOD);

    // 5: BREATHE and BLINK over many periods
    send(2, 3, 'hFF, 'hFF, 'hFF);
    send(1, 2, 'hAA, 'h55, 'h00);
    run(40 * PERIOD);

    // random configs with random gaps
    for (int k = 0; k < 20; k++) begin
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)));
      run(int'($urandom_range(0, 400)));
    end

    // 6: reset with an update pending -> update is dropped
    wait_at(50);
    send(0, 1, 'hFF, 'hFF, 'hFF);
    run(20);
    check("t6_pending", 32'(cfg_ready), 32'(0));
    do_reset("rst6");
    run(2 * PERIOD + 10);
    check("t6_led_r", 32'(led_r), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
